// File: rtl/pipe_hazard_if.sv
// Hazard-controller bundle: pipeline-side hazard inputs and the stall/flush/forward controls.
// The master side is the pipeline datapath; the slave side is pipe_hazard_ctrl.
interface pipe_hazard_if #(
    parameter int PERF_W = 32
);
    logic [4:0]        Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic              regWriteM, regWriteW;
    logic [1:0]        resultSrcE;
    logic              PCSrcE, memReqM, memAckM, errClr;
    logic              stallF, stallD, stallE, stallM;
    logic              flushD, flushE, bubbleW, memErr;
    logic [1:0]        forwardAE, forwardBE;
    logic [PERF_W-1:0] stallCycles, loadUseCnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, regWriteM, regWriteW,
               resultSrcE, PCSrcE, memReqM, memAckM, errClr,
        input  stallF, stallD, stallE, stallM, flushD, flushE, bubbleW, memErr,
               forwardAE, forwardBE, stallCycles, loadUseCnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, regWriteM, regWriteW,
               resultSrcE, PCSrcE, memReqM, memAckM, errClr,
        output stallF, stallD, stallE, stallM, flushD, flushE, bubbleW, memErr,
               forwardAE, forwardBE, stallCycles, loadUseCnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding, load-use and data-memory wait FSM.
// Define HAZARD_PERF_EN to build the saturating stall/load-use performance counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5,
    parameter int PERF_W      = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_hazard_if.slave hz
);
    // state | meaning
    // IDLE  | no outstanding data-memory access
    // WAIT  | access issued, waiting for memAckM, cnt counts wait cycles
    // ERR   | no ack within MEM_TIMEOUT wait cycles; pipeline frozen until errClr
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_ERR = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_stall, lw_stall, stall_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (hz.memReqM && !hz.memAckM) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (hz.memAckM) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ERR: begin
                if (hz.errClr) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are gated by rst_n so every control is quiet while reset is held.
    always_comb begin
        mem_stall = 1'b0;
        case (state_q)
            ST_IDLE: mem_stall = hz.memReqM && !hz.memAckM;
            ST_WAIT: mem_stall = !hz.memAckM;
            ST_ERR:  mem_stall = 1'b1;
            default: mem_stall = 1'b0;
        endcase
        mem_stall = mem_stall && rst_n;

        lw_stall = rst_n && (hz.resultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                   ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
        stall_f  = lw_stall || mem_stall;

        hz.stallF  = stall_f;
        hz.stallD  = stall_f;
        hz.stallE  = mem_stall;
        hz.stallM  = mem_stall;
        hz.bubbleW = mem_stall;
        hz.flushD  = rst_n && hz.PCSrcE && !mem_stall;
        hz.flushE  = rst_n && (lw_stall || hz.PCSrcE) && !mem_stall;
        hz.memErr  = rst_n && (state_q == ST_ERR);

        hz.forwardAE = 2'b00;
        if (rst_n && hz.regWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs1E)
            hz.forwardAE = 2'b10;
        else if (rst_n && hz.regWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs1E)
            hz.forwardAE = 2'b01;

        hz.forwardBE = 2'b00;
        if (rst_n && hz.regWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs2E)
            hz.forwardBE = 2'b10;
        else if (rst_n && hz.regWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs2E)
            hz.forwardBE = 2'b01;
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [PERF_W-1:0] load_use_cnt_q, load_use_cnt_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        load_use_cnt_d = load_use_cnt_q;
        if (stall_f && !(&stall_cycles_q))
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        if (lw_stall && !mem_stall && !(&load_use_cnt_q))
            load_use_cnt_d = load_use_cnt_q + PERF_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            load_use_cnt_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            load_use_cnt_q <= load_use_cnt_d;
        end
    end

    assign hz.stallCycles = stall_cycles_q;
    assign hz.loadUseCnt  = load_use_cnt_q;
`else
    assign hz.stallCycles = '0;
    assign hz.loadUseCnt  = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the hazard rules and memory handshake.
module tb_pipe_hazard_ctrl;
    localparam int T      = 4;
    localparam int PERF_W = 32;
    localparam longint SAT = longint'((64'd1 << PERF_W) - 64'd1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_if #(.PERF_W(PERF_W)) hz ();
    pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(5), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst_n(rst_n), .hz(hz)
    );

    int n_checks = 0;
    int n_errors = 0;

    // model: is an access pending, how many wait cycles have elapsed, are we in error
    bit     m_busy, m_err;
    int     m_waited;
    longint m_stall_cnt, m_lu_cnt;

    logic [11:0] dut_out;
    assign dut_out = {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushD, hz.flushE,
                      hz.bubbleW, hz.memErr, hz.forwardAE, hz.forwardBE};

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (hz.regWriteM && hz.RdM != 0 && hz.RdM == rs) return 2'b10;
        if (hz.regWriteW && hz.RdW != 0 && hz.RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit lw_ref();
        return hz.resultSrcE == 2'b01 && hz.RdE != 0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    endfunction

    function automatic bit mstall_ref();
        if (m_err) return 1'b1;
        if (m_busy) return !hz.memAckM;
        return hz.memReqM && !hz.memAckM;
    endfunction

    function automatic logic [11:0] exp_out();
        bit ms = mstall_ref();
        bit lw = lw_ref();
        return {lw | ms, lw | ms, ms, ms, hz.PCSrcE & ~ms, (lw | hz.PCSrcE) & ~ms, ms, m_err,
                fwd_ref(hz.Rs1E), fwd_ref(hz.Rs2E)};
    endfunction

    task automatic model_step();
        bit ms = mstall_ref();
        bit lw = lw_ref();
        if ((lw || ms) && m_stall_cnt < SAT) m_stall_cnt++;
        if (lw && !ms && m_lu_cnt < SAT) m_lu_cnt++;
        if (m_err) begin
            if (hz.errClr) m_err = 0;
        end else if (m_busy) begin
            if (hz.memAckM) m_busy = 0;
            else if (m_waited == T - 1) begin m_busy = 0; m_err = 1; end
            else m_waited++;
        end else if (hz.memReqM && !hz.memAckM) begin
            m_busy = 1;
            m_waited = 0;
        end
    endtask

    task automatic clear_inputs();
        {hz.Rs1D, hz.Rs2D, hz.Rs1E, hz.Rs2E, hz.RdE, hz.RdM, hz.RdW} = '0;
        {hz.regWriteM, hz.regWriteW, hz.PCSrcE, hz.memReqM, hz.memAckM, hz.errClr} = '0;
        hz.resultSrcE = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        m_busy = 0; m_err = 0; m_waited = 0; m_stall_cnt = 0; m_lu_cnt = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hz.regWriteM = 1; hz.RdM = 5; hz.Rs1E = 5; hz.Rs2E = 5;
        hz.memReqM = 1; hz.PCSrcE = 1; hz.resultSrcE = 2'b01; hz.RdE = 3; hz.Rs1D = 3;
        #1;
        n_checks++;
        if (dut_out !== 12'h000) begin
            n_errors++; $display("FAIL reset_outputs: got %h want 000", dut_out);
        end
        n_checks++;
        if (hz.stallCycles !== '0 || hz.loadUseCnt !== '0) begin
            n_errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", hz.stallCycles, hz.loadUseCnt);
        end
    endtask

    task automatic test_forwarding();
        do_reset();
        @(negedge clk);
        hz.RdM = 5; hz.regWriteM = 1; hz.RdW = 5; hz.regWriteW = 1; hz.Rs1E = 5; hz.Rs2E = 9;
        #1;
        n_checks++;
        if (hz.forwardAE !== 2'b10) begin
            n_errors++; $display("FAIL fwd_m_priority: got %b want 10", hz.forwardAE);
        end
        hz.RdM = 0; #1;
        n_checks++;
        if (hz.forwardAE !== 2'b01) begin
            n_errors++; $display("FAIL fwd_w: got %b want 01", hz.forwardAE);
        end
        hz.Rs2E = 0; hz.RdW = 0; #1;
        n_checks++;
        if (hz.forwardBE !== 2'b00 || hz.forwardAE !== 2'b00) begin
            n_errors++; $display("FAIL fwd_x0: got %b/%b want 00/00", hz.forwardAE, hz.forwardBE);
        end
        hz.RdM = 9; hz.Rs2E = 9; hz.regWriteM = 0; hz.RdW = 9; #1;
        n_checks++;
        if (hz.forwardBE !== 2'b01) begin
            n_errors++; $display("FAIL fwd_b_w_no_m_we: got %b want 01", hz.forwardBE);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk);
        hz.resultSrcE = 2'b01; hz.RdE = 7; hz.Rs2D = 7; hz.Rs1D = 3;
        #1;
        n_checks++;
        if ({hz.stallF, hz.stallD, hz.flushE, hz.stallE, hz.stallM, hz.flushD} !== 6'b111000) begin
            n_errors++; $display("FAIL load_use: got %b want 111000",
                {hz.stallF, hz.stallD, hz.flushE, hz.stallE, hz.stallM, hz.flushD});
        end
        @(negedge clk);
        hz.resultSrcE = 2'b00; hz.RdE = 0;
        #1;
        n_checks++;
        if ({hz.stallF, hz.stallD, hz.flushE} !== 3'b000) begin
            n_errors++; $display("FAIL load_use_release: got %b want 000", {hz.stallF, hz.stallD, hz.flushE});
        end
`ifdef HAZARD_PERF_EN
        n_checks++;
        if (hz.loadUseCnt !== PERF_W'(1) || hz.stallCycles !== PERF_W'(1)) begin
            n_errors++; $display("FAIL perf_load_use: got %0d/%0d want 1/1", hz.loadUseCnt, hz.stallCycles);
        end
`endif
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            hz.memReqM = 1; hz.memAckM = (c == 3);
            #1;
            n_checks++;
            if ({hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.bubbleW} !== ((c < 3) ? 5'b11111 : 5'b00000)) begin
                n_errors++; $display("FAIL mem_wait c%0d: got %b want %b", c,
                    {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.bubbleW}, (c < 3) ? 5'b11111 : 5'b00000);
            end
        end
        @(negedge clk); hz.memReqM = 1; hz.memAckM = 1; #1;
        n_checks++;
        if (hz.stallM !== 1'b0) begin
            n_errors++; $display("FAIL zero_wait: got %b want 0", hz.stallM);
        end
        @(negedge clk); hz.memReqM = 0; hz.memAckM = 0; #1;
        n_checks++;
        if (hz.stallM !== 1'b0) begin
            n_errors++; $display("FAIL idle_after_zero_wait: got %b want 0", hz.stallM);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); hz.memReqM = 1; hz.memAckM = 0; #1;
            n_checks++;
            if (hz.memErr !== (c >= 5) || hz.stallF !== 1'b1) begin
                n_errors++; $display("FAIL timeout c%0d: memErr=%b stallF=%b want %b/1", c, hz.memErr, hz.stallF, c >= 5);
            end
        end
        @(negedge clk); hz.memReqM = 0; hz.errClr = 1; #1;
        n_checks++;
        if (hz.memErr !== 1'b1 || hz.stallE !== 1'b1) begin
            n_errors++; $display("FAIL err_hold: memErr=%b stallE=%b want 1/1", hz.memErr, hz.stallE);
        end
        @(negedge clk); hz.errClr = 0; #1;
        n_checks++;
        if (hz.memErr !== 1'b0 || hz.stallF !== 1'b0) begin
            n_errors++; $display("FAIL err_clear: memErr=%b stallF=%b want 0/0", hz.memErr, hz.stallF);
        end
    endtask

    task automatic test_branch_in_stall();
        do_reset();
        @(negedge clk); hz.memReqM = 1; hz.memAckM = 0;
        @(negedge clk); hz.PCSrcE = 1; #1;
        n_checks++;
        if ({hz.flushD, hz.flushE, hz.stallF} !== 3'b001) begin
            n_errors++; $display("FAIL branch_in_wait: got %b want 001", {hz.flushD, hz.flushE, hz.stallF});
        end
        @(negedge clk); hz.memAckM = 1; #1;
        n_checks++;
        if ({hz.flushD, hz.flushE, hz.stallF} !== 3'b110) begin
            n_errors++; $display("FAIL branch_on_ack: got %b want 110", {hz.flushD, hz.flushE, hz.stallF});
        end
        @(negedge clk); hz.memReqM = 0; hz.memAckM = 0;
        hz.resultSrcE = 2'b01; hz.RdE = 4; hz.Rs1D = 4; #1;
        n_checks++;
        if ({hz.flushD, hz.flushE, hz.stallF, hz.stallE} !== 4'b1110) begin
            n_errors++; $display("FAIL branch_with_lw: got %b want 1110", {hz.flushD, hz.flushE, hz.stallF, hz.stallE});
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); hz.memReqM = 1; hz.memAckM = 0;
        end
        hz.regWriteM = 1; hz.RdM = 6; hz.Rs1E = 6; hz.PCSrcE = 1;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_out !== 12'h000) begin
            n_errors++; $display("FAIL async_reset_mid_wait: got %h want 000", dut_out);
        end
        @(negedge clk);
        clear_inputs();
        #2 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); hz.memReqM = 1; #1;
            n_checks++;
            if (hz.memErr !== (c >= 5)) begin
                n_errors++; $display("FAIL post_reset_timeout c%0d: got %b want %b", c, hz.memErr, c >= 5);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            hz.Rs1D = 5'($urandom_range(0, 7)); hz.Rs2D = 5'($urandom_range(0, 7));
            hz.Rs1E = 5'($urandom_range(0, 7)); hz.Rs2E = 5'($urandom_range(0, 7));
            hz.RdE  = 5'($urandom_range(0, 7)); hz.RdM  = 5'($urandom_range(0, 7));
            hz.RdW  = 5'($urandom_range(0, 7));
            hz.regWriteM = ($urandom_range(0, 1) == 1); hz.regWriteW = ($urandom_range(0, 1) == 1);
            hz.resultSrcE = 2'($urandom_range(0, 3));
            hz.PCSrcE  = ($urandom_range(0, 3) == 0);
            hz.memReqM = ($urandom_range(0, 1) == 1);
            hz.memAckM = ($urandom_range(0, 2) == 0);
            hz.errClr  = ($urandom_range(0, 7) == 0);
            #1;
            n_checks++;
            if (dut_out !== exp_out()) begin
                n_errors++; $display("FAIL random_outputs i=%0d: got %h want %h", i, dut_out, exp_out());
            end
            n_checks++;
`ifdef HAZARD_PERF_EN
            if (hz.stallCycles !== PERF_W'(m_stall_cnt) || hz.loadUseCnt !== PERF_W'(m_lu_cnt)) begin
                n_errors++; $display("FAIL random_perf i=%0d: got %0d/%0d want %0d/%0d", i,
                    hz.stallCycles, hz.loadUseCnt, m_stall_cnt, m_lu_cnt);
            end
`else
            if (hz.stallCycles !== '0 || hz.loadUseCnt !== '0) begin
                n_errors++; $display("FAIL random_perf_tied i=%0d: got %0d/%0d want 0/0", i,
                    hz.stallCycles, hz.loadUseCnt);
            end
`endif
            @(posedge clk);
            model_step();
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_branch_in_stall();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
